// File: rtl/bus_sram_slave.sv
// Single-window SRAM slave for the shared wired-OR system bus.
// All outputs are registered and held at zero whenever the block is not responding.
module bus_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK = ~((32'(DEPTH) << 2) - 32'd1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_BURST = 3'd2;
  localparam logic [2:0] ST_WR_BURST = 3'd3;
  localparam logic [2:0] ST_WR_DRAIN = 3'd4;
  localparam logic [2:0] ST_ERR_RESP = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    be_q, be_d;
  logic          rdErr_q, rdErr_d;

  logic [31:0]   dataOut_q, dataOut_d;
  logic          endOut_q, endOut_d;
  logic          validOut_q, validOut_d;
  logic          busyOut_q, busyOut_d;
  logic          errOut_q, errOut_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ramData_q;
  logic [AW-1:0] ramAddr;
  logic [AW-1:0] beginIdx;
  logic [31:0]   endIdx;
  logic          hit;
  logic          badReq;
  logic          accept;
  logic          wrBeat;

  assign hit      = (bus_addrData_i & WIN_MASK) == BASE_ADDR;
  assign beginIdx = bus_addrData_i[AW+1:2];
  assign endIdx   = 32'(beginIdx) + 32'(bus_burstSize_i);
  assign badReq   = (bus_burstSize_i == 8'd0) || (endIdx > 32'(DEPTH));
  assign accept   = bus_beginTransaction_i && hit && (state_q == ST_IDLE);
  assign wrBeat   = (state_q == ST_WR_BURST) && bus_dataValid_i && (cnt_q != 8'd0) && !rst;
  // In IDLE the RAM is addressed straight from the bus so the first word is ready one cycle after begin.
  assign ramAddr  = (state_q == ST_IDLE) ? beginIdx : idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    rdErr_d = rdErr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = bus_burstSize_i;
          be_d  = bus_byteEnables_i;
          if (bus_readNWrite_i) begin
            state_d = ST_RD_ISSUE;
            rdErr_d = badReq;
            idx_d   = beginIdx + AW'(1);
          end else begin
            state_d = badReq ? ST_WR_DRAIN : ST_WR_BURST;
            idx_d   = beginIdx;
          end
        end
      end
      // A rejected read still spends one busy cycle here so the error lands two cycles after begin.
      ST_RD_ISSUE: begin
        state_d = rdErr_q ? ST_ERR_RESP : ST_RD_BURST;
        idx_d   = idx_q + AW'(1);
      end
      ST_RD_BURST: begin
        idx_d = idx_q + AW'(1);
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_IDLE;
      end
      ST_WR_BURST: begin
        if (bus_dataValid_i) begin
          if (cnt_q != 8'd0) begin
            idx_d = idx_q + AW'(1);
            cnt_d = cnt_q - 8'd1;
          end
          if (bus_endTransaction_i) state_d = ST_IDLE;
        end
      end
      ST_WR_DRAIN: begin
        if (bus_dataValid_i && bus_endTransaction_i) state_d = ST_ERR_RESP;
      end
      ST_ERR_RESP: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    validOut_d = (state_d == ST_RD_BURST);
    dataOut_d  = validOut_d ? ramData_q : 32'd0;
    endOut_d   = ((state_d == ST_RD_BURST) && (cnt_d == 8'd1)) || (state_d == ST_ERR_RESP);
    busyOut_d  = (state_d == ST_RD_ISSUE) || (state_d == ST_RD_BURST) || (state_d == ST_ERR_RESP);
    errOut_d   = (state_d == ST_ERR_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      be_q       <= '0;
      rdErr_q    <= 1'b0;
      dataOut_q  <= '0;
      endOut_q   <= 1'b0;
      validOut_q <= 1'b0;
      busyOut_q  <= 1'b0;
      errOut_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      be_q       <= be_d;
      rdErr_q    <= rdErr_d;
      dataOut_q  <= dataOut_d;
      endOut_q   <= endOut_d;
      validOut_q <= validOut_d;
      busyOut_q  <= busyOut_d;
      errOut_q   <= errOut_d;
    end
  end

  // Block RAM with per-byte write enables; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wrBeat) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= bus_addrData_i[8*b +: 8];
      end
    end
    ramData_q <= mem[ramAddr];
  end

  assign bus_addrData_o       = dataOut_q;
  assign bus_endTransaction_o = endOut_q;
  assign bus_dataValid_o      = validOut_q;
  assign bus_busy_o           = busyOut_q;
  assign bus_error_o          = errOut_q;

endmodule

// File: doc/bus_sram_slave.md
# bus_sram_slave

Memory-mapped on-chip SRAM responder for the shared wired-OR system bus driven by the CPU bus master. It sits beside the SPART as a second bus slave. It decodes its address window and services single-beat and burst reads and writes, with byte enables on writes. It drives all bus outputs to zero whenever it is not responding, so its outputs can be ORed directly onto the bus.

## Interface
- BASE_ADDR, 32'h0001_0000: window base address; must be aligned to DEPTH*4.
- DEPTH, 1024: number of 32-bit words; power of two, 2 to 65536. AW = log2(DEPTH).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- bus_addrData_i  in  32  address on the begin cycle; write data on data beats.
- bus_byteEnables_i  in  4  write byte lanes; sampled on the begin cycle.
- bus_burstSize_i  in  8  beat count; sampled on the begin cycle.
- bus_readNWrite_i  in  1  1 = read, 0 = write; sampled on the begin cycle.
- bus_beginTransaction_i  in  1  start of a transaction.
- bus_endTransaction_i  in  1  last write beat, from the master.
- bus_dataValid_i  in  1  write beat valid.
- bus_addrData_o  out  32  read data; 0 when not driving.
- bus_endTransaction_o  out  1  last read beat, or error termination.
- bus_dataValid_o  out  1  read beat valid.
- bus_busy_o  out  1  slave occupied by a read or error response.
- bus_error_o  out  1  one-cycle pulse: transaction rejected.

## Operation
- Address decode: hit = (addr & ~(DEPTH*4-1)) == BASE_ADDR. Word index = addr[AW+1:2]. addr[1:0] is ignored.
- A begin with no hit is ignored entirely. The block stays IDLE with all outputs 0.
- Begin is honoured only in IDLE. In any other state it is ignored.
- Error condition at begin: burstSize == 0, or index + burstSize > DEPTH (burst would cross the window end).
- States:
  - IDLE
  - RD_ISSUE
  - RD_BURST
  - WR_BURST
  - WR_DRAIN (error write)
  - ERR_RESP
- IDLE, hit, read, no error -> RD_ISSUE. Latch index, beat count = burstSize. Issue a synchronous RAM read of the index.
- RD_ISSUE -> RD_BURST. The RAM read address advances each cycle, so one beat is produced per cycle.
- RD_BURST, each cycle:
  - Drive dataValid_o = 1 and addrData_o = RAM word.
  - Decrement the remaining count.
  - On the last beat, assert endTransaction_o = 1 and go to IDLE.
  - No stalls.
- During RD_ISSUE and RD_BURST, ignore bus_dataValid_i and bus_endTransaction_i. These carry the block's own ORed outputs.
- IDLE, hit, write, no error -> WR_BURST. Latch index and byteEnables.
- WR_BURST, each cycle with dataValid_i = 1:
  - Write addrData_i to the current index, per-byte masked by the latched enables.
  - Increment the index.
  - If endTransaction_i = 1, return to IDLE after this beat.
- Beats beyond burstSize are dropped: no RAM write, no index advance. The block still waits for endTransaction_i.
- Reads: error at begin -> ERR_RESP. Write: error at begin -> WR_DRAIN.
- WR_DRAIN consumes beats without writing. On the beat with endTransaction_i, go to ERR_RESP.
- ERR_RESP lasts one cycle: error_o = 1, endTransaction_o = 1, dataValid_o = 0, addrData_o = 0. Then -> IDLE.
- bus_busy_o = 1 in RD_ISSUE, RD_BURST and ERR_RESP; 0 otherwise. Writes never assert busy, so the master streams data without stalls.
- Reads ignore byteEnables and always return the full word.
- RAM is inferred block RAM. Contents are not reset.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- Reset mid-transaction: outputs read 0 on the cycle after rst is sampled high, and the state is IDLE. A partially written burst keeps the beats already written.
- Read latency: begin sampled in cycle T. busy_o = 1 from T+1. Beat k (k = 1..N) has dataValid_o = 1 in cycle T+1+k. endTransaction_o is asserted with beat N in cycle T+1+N. busy_o drops in T+2+N.
- Write: a beat sampled in cycle W is visible to a read begun in cycle W+1 or later.
- Error read: begin in T -> error_o and endTransaction_o in T+2, busy_o in T+1..T+2.
- Error write: master endTransaction_i in cycle E -> error_o pulse in E+1.
- Begin and a data beat in the same cycle while IDLE: only the begin is processed.

## Test plan
- Write 32'hDEAD_BEEF to 0x0001_0010 (burst 1, BE = 4'hF), then read it back -> dataValid_o and endTransaction_o set with data 32'hDEAD_BEEF, exactly 2 cycles after begin.
- Fill word 4 with 32'h1111_1111, then write 32'hAABB_CCDD with BE = 4'b0101 -> read returns 32'h11BB_11DD.
- Write words 0..3 = 1,2,3,4, then issue a 4-beat read at 0x0001_0000 -> data 1,2,3,4 on 4 consecutive cycles, end only on beat 4, busy held for 5 cycles.
- Read at 0x0002_0000 -> all outputs stay 0 for 10 cycles.
- Read at index 1022 with burst 4 -> no dataValid_o; error_o and endTransaction_o pulse at T+2. A 3-beat write to the same address -> RAM unchanged and error_o pulses the cycle after the master's end.
- Assert rst during beat 2 of an 8-beat read -> all outputs 0 the next cycle. A following single read completes normally.
